// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - game-loop frame sequencer: draw passes, frame-tick divider, winner decision
// Define PAUSE_EN to add a pause input that holds the FSM in GAME_IDLE.
module frame_sequencer #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BOMBS   = 6,
  parameter int LIFE_W      = 2,
  parameter int TICK_DIV    = 833333,
  parameter int FRAME_DIV   = 15,
  localparam int PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int IW = ($clog2(NUM_BOMBS) > LIFE_W) ? $clog2(NUM_BOMBS) : LIFE_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          go,
  input  logic                          draw_done,
  input  logic                          all_tiles_drawn,
  input  logic [NUM_PLAYERS*LIFE_W-1:0] lives,
`ifdef PAUSE_EN
  input  logic                          pause,
`endif
  output logic [1:0]                    screen_sel,
  output logic                          copy_enable,
  output logic [2:0]                    pass,
  output logic [IW-1:0]                 draw_idx,
  output logic [PW-1:0]                 draw_player,
  output logic [1:0]                    corner_id,
  output logic                          tc_enable,
  output logic                          player_reset,
  output logic                          tile_reset,
  output logic                          refresh,
  output logic                          game_over,
  output logic [PW-1:0]                 winner,
  output logic                          winner_valid
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = ($clog2(FRAME_DIV) > 1) ? $clog2(FRAME_DIV) : 1;

  // Order matters: DRAW_TILE..UPDATE_STAGE is the contiguous range where the tick divider runs.
  typedef enum logic [4:0] {
    S_LOAD_TITLE, S_TITLE, S_LOAD_STAGE,
    S_DRAW_TILE, S_DRAW_EXPL, S_NEXT_TILE, S_DRAW_BOMB, S_NEXT_BOMB,
    S_PLAYER_START, S_CHECK_CORNER, S_NEXT_CORNER, S_DRAW_PLAYER, S_DRAW_HP,
    S_NEXT_HP, S_NEXT_PLAYER, S_GAME_IDLE, S_UPDATE_STAGE,
    S_LOAD_WIN, S_WIN
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [IW-1:0]   bomb_q, bomb_d, hp_q, hp_d, hp_limit_q, hp_limit_d;
  logic [PW-1:0]   player_q, player_d;
  logic [1:0]      corner_q, corner_d;
  logic            run, tick, paused, frame_en;
  logic [LIFE_W-1:0] cur_lives;
  logic [PW:0]     alive_count;
  logic [PW-1:0]   first_alive;

`ifdef PAUSE_EN
  assign paused = pause && (state_q == S_GAME_IDLE);
`else
  assign paused = 1'b0;
`endif

  assign run      = (state_q >= S_DRAW_TILE) && (state_q <= S_UPDATE_STAGE);
  assign tick     = run && (tick_q == TW'(TICK_DIV - 1));
  assign frame_en = tick && !paused;
  assign refresh  = frame_en && (frame_q == FW'(FRAME_DIV - 1));

  // Descending scan leaves first_alive at the lowest alive index.
  always_comb begin
    cur_lives   = '0;
    alive_count = '0;
    first_alive = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (lives[p*LIFE_W +: LIFE_W] != '0) begin
        alive_count = alive_count + (PW+1)'(1);
        first_alive = PW'(p);
      end
      if (player_q == PW'(p)) cur_lives = lives[p*LIFE_W +: LIFE_W];
    end
  end

  assign game_over    = (state_q == S_LOAD_WIN) || (state_q == S_WIN);
  assign winner       = game_over ? first_alive : '0;
  assign winner_valid = game_over && (alive_count == (PW+1)'(1));

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    frame_d    = frame_q;
    bomb_d     = bomb_q;
    hp_d       = hp_q;
    hp_limit_d = hp_limit_q;
    player_d   = player_q;
    corner_d   = corner_q;
    if (run) tick_d = tick ? '0 : tick_q + TW'(1);
    if (frame_en) frame_d = (frame_q == FW'(FRAME_DIV - 1)) ? '0 : frame_q + FW'(1);
    unique case (state_q)
      S_LOAD_TITLE: if (draw_done) state_d = S_TITLE;
      S_TITLE:      if (go) state_d = S_LOAD_STAGE;
      S_LOAD_STAGE: begin
        tick_d   = '0;
        frame_d  = '0;
        bomb_d   = '0;
        hp_d     = '0;
        player_d = '0;
        corner_d = '0;
        if (draw_done) state_d = S_DRAW_TILE;
      end
      S_DRAW_TILE:  if (draw_done) state_d = S_DRAW_EXPL;
      S_DRAW_EXPL:  if (draw_done) state_d = S_NEXT_TILE;
      S_NEXT_TILE:  state_d = all_tiles_drawn ? S_DRAW_BOMB : S_DRAW_TILE;
      S_DRAW_BOMB:  if (draw_done) state_d = S_NEXT_BOMB;
      S_NEXT_BOMB: begin
        if (bomb_q == IW'(NUM_BOMBS - 1)) begin
          bomb_d  = '0;
          state_d = S_PLAYER_START;
        end else begin
          bomb_d  = bomb_q + IW'(1);
          state_d = S_DRAW_BOMB;
        end
      end
      S_PLAYER_START: begin
        hp_limit_d = IW'(cur_lives);
        corner_d   = '0;
        hp_d       = '0;
        state_d    = (cur_lives == '0) ? S_NEXT_PLAYER : S_CHECK_CORNER;
      end
      S_CHECK_CORNER: state_d = S_NEXT_CORNER;
      S_NEXT_CORNER: begin
        corner_d = corner_q + 2'd1;
        state_d  = (corner_q == 2'd3) ? S_DRAW_PLAYER : S_CHECK_CORNER;
      end
      S_DRAW_PLAYER: if (draw_done) state_d = S_DRAW_HP;
      S_DRAW_HP:     if (draw_done) state_d = S_NEXT_HP;
      S_NEXT_HP: begin
        if (hp_q == hp_limit_q - IW'(1)) begin
          hp_d    = '0;
          state_d = S_NEXT_PLAYER;
        end else begin
          hp_d    = hp_q + IW'(1);
          state_d = S_DRAW_HP;
        end
      end
      S_NEXT_PLAYER: begin
        if (player_q == PW'(NUM_PLAYERS - 1)) begin
          player_d = '0;
          state_d  = S_GAME_IDLE;
        end else begin
          player_d = player_q + PW'(1);
          state_d  = S_PLAYER_START;
        end
      end
      S_GAME_IDLE:    if (tick && !paused) state_d = S_UPDATE_STAGE;
      S_UPDATE_STAGE: state_d = (alive_count <= (PW+1)'(1)) ? S_LOAD_WIN : S_DRAW_TILE;
      S_LOAD_WIN:     if (draw_done) state_d = S_WIN;
      S_WIN:          if (go) state_d = S_LOAD_TITLE;
      default:        state_d = S_LOAD_TITLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD_TITLE;
      tick_q     <= '0;
      frame_q    <= '0;
      bomb_q     <= '0;
      hp_q       <= '0;
      hp_limit_q <= '0;
      player_q   <= '0;
      corner_q   <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      frame_q    <= frame_d;
      bomb_q     <= bomb_d;
      hp_q       <= hp_d;
      hp_limit_q <= hp_limit_d;
      player_q   <= player_d;
      corner_q   <= corner_d;
    end
  end

  always_comb begin
    screen_sel   = 2'd3;
    copy_enable  = 1'b0;
    pass         = 3'd0;
    draw_idx     = '0;
    tc_enable    = 1'b0;
    player_reset = 1'b0;
    tile_reset   = 1'b0;
    unique case (state_q)
      S_LOAD_TITLE: begin screen_sel = 2'd0; copy_enable = 1'b1; pass = 3'd1; end
      S_TITLE:      screen_sel = 2'd0;
      S_LOAD_STAGE: begin
        screen_sel   = 2'd1;
        copy_enable  = 1'b1;
        pass         = 3'd1;
        player_reset = 1'b1;
        tile_reset   = 1'b1;
      end
      S_DRAW_TILE:    pass = 3'd2;
      S_DRAW_EXPL:    pass = 3'd3;
      S_NEXT_TILE:    tc_enable = 1'b1;
      S_DRAW_BOMB:    begin pass = 3'd4; draw_idx = bomb_q; end
      S_CHECK_CORNER: pass = 3'd5;
      S_DRAW_PLAYER:  pass = 3'd6;
      S_DRAW_HP:      begin pass = 3'd7; draw_idx = hp_q; end
      S_LOAD_WIN:     begin screen_sel = 2'd2; copy_enable = 1'b1; pass = 3'd1; end
      S_WIN:          screen_sel = 2'd2;
      default: ;
    endcase
  end

  assign draw_player = player_q;
  assign corner_id   = corner_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer (3 players, 2 bombs, TICK_DIV 4, FRAME_DIV 3)
module tb_frame_sequencer;
  localparam int NP = 3, NB = 2, LW = 2, TD = 4, FD = 3;

  logic clock = 1'b0, reset = 1'b1, go = 1'b0, draw_done = 1'b0;
  logic all_tiles_drawn;
  logic [NP*LW-1:0] lives;
`ifdef PAUSE_EN
  logic pause;
`endif
  logic [1:0] screen_sel, draw_idx, draw_player, corner_id, winner;
  logic [2:0] pass;
  logic copy_enable, tc_enable, player_reset, tile_reset, refresh, game_over, winner_valid;

  typedef struct packed {
    logic [2:0] pass;
    logic [1:0] idx;
    logic [1:0] player;
    logic [1:0] corner;
  } ev_t;

  ev_t sb[$];
  ev_t exp_e;
  int  n_cmp = 0, n_fail = 0, n_events = 0, k;
  logic auto_done = 1'b0, mon_en = 1'b1, seen = 1'b0, tile_q = 1'b0, ok;

  frame_sequencer #(.NUM_PLAYERS(NP), .NUM_BOMBS(NB), .LIFE_W(LW), .TICK_DIV(TD), .FRAME_DIV(FD)) dut (
    .clock(clock), .reset(reset), .go(go), .draw_done(draw_done),
    .all_tiles_drawn(all_tiles_drawn), .lives(lives),
`ifdef PAUSE_EN
    .pause(pause),
`endif
    .screen_sel(screen_sel), .copy_enable(copy_enable), .pass(pass), .draw_idx(draw_idx),
    .draw_player(draw_player), .corner_id(corner_id), .tc_enable(tc_enable),
    .player_reset(player_reset), .tile_reset(tile_reset), .refresh(refresh),
    .game_over(game_over), .winner(winner), .winner_valid(winner_valid)
  );

  always #5 clock = ~clock;

  // Datapath stand-in: acknowledges each draw request one cycle after it appears.
  always @(posedge clock) begin
    #1;
    if (reset || !auto_done) begin
      draw_done = 1'b0;
      seen = 1'b0;
    end else if (seen && !draw_done && pass != 3'd0 && pass != 3'd5) begin
      draw_done = 1'b1;
      seen = 1'b0;
    end else begin
      draw_done = 1'b0;
      seen = (pass != 3'd0 && pass != 3'd5);
    end
  end

  // Two-tile walker.
  always @(posedge clock or posedge reset) begin
    if (reset) tile_q <= 1'b0;
    else if (tile_reset) tile_q <= 1'b0;
    else if (tc_enable) tile_q <= ~tile_q;
  end
  assign all_tiles_drawn = tile_q;

  always @(negedge clock) begin
    if (!reset && mon_en && (pass == 3'd5 ||
        ((pass == 3'd4 || pass == 3'd6 || pass == 3'd7) && draw_done))) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_draw: pass=%0d player=%0d idx=%0d, no draw expected", pass, draw_player, draw_idx);
      end else begin
        exp_e = sb.pop_front();
        n_events++;
        ok = (pass == exp_e.pass) && (draw_player == exp_e.player) &&
             ((exp_e.pass != 3'd4 && exp_e.pass != 3'd7) || draw_idx == exp_e.idx) &&
             (exp_e.pass != 3'd5 || corner_id == exp_e.corner);
        if (!ok) begin
          n_fail++;
          $display("FAIL draw_event %0d: got pass=%0d player=%0d idx=%0d corner=%0d expected pass=%0d player=%0d idx=%0d corner=%0d",
                   n_events, pass, draw_player, draw_idx, corner_id,
                   exp_e.pass, exp_e.player, exp_e.idx, exp_e.corner);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] p, input logic [1:0] i, input logic [1:0] pl, input logic [1:0] c);
    ev_t e;
    e.pass = p; e.idx = i; e.player = pl; e.corner = c;
    sb.push_back(e);
  endtask

  task automatic push_frame(input int icons0, input int icons2);
    push(3'd4, 2'd0, 2'd0, 2'd0);
    push(3'd4, 2'd1, 2'd0, 2'd0);
    for (int c = 0; c < 4; c++) push(3'd5, 2'd0, 2'd0, 2'(c));
    push(3'd6, 2'd0, 2'd0, 2'd0);
    for (int i = 0; i < icons0; i++) push(3'd7, 2'(i), 2'd0, 2'd0);
    for (int c = 0; c < 4; c++) push(3'd5, 2'd0, 2'd2, 2'(c));
    push(3'd6, 2'd0, 2'd2, 2'd0);
    for (int i = 0; i < icons2; i++) push(3'd7, 2'(i), 2'd2, 2'd0);
  endtask

  initial begin
    lives = {2'd1, 2'd0, 2'd3};
`ifdef PAUSE_EN
    pause = 1'b1;
`endif
    repeat (3) @(negedge clock);
    check("reset_screen_sel", screen_sel, 0);
    check("reset_copy_enable", copy_enable, 1);
    check("reset_pass", pass, 1);
    check("reset_others", {tc_enable, player_reset, tile_reset, refresh, game_over, winner_valid, winner, draw_idx, draw_player, corner_id}, 0);
    reset = 1'b0;
    auto_done = 1'b1;

    k = 0;
    while (!(pass == 3'd0 && screen_sel == 2'd0) && k < 20) begin @(negedge clock); k++; end
    check("title_reached", k < 20, 1);

    push_frame(3, 1);
    push_frame(1, 1);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    check("load_stage_outputs", {screen_sel, copy_enable, pass, player_reset, tile_reset}, {2'd1, 1'b1, 3'd1, 1'b1, 1'b1});

    k = 0;
    while (pass != 3'd2 && k < 10) begin @(negedge clock); k++; end
    check("first_draw_tile", pass, 2);
    k = 0;
    while (!refresh && k < 40) begin @(negedge clock); k++; end
    check("first_refresh_delay", k, 11);
    @(negedge clock);
    check("refresh_one_cycle", refresh, 0);
    k = 1;
    while (!refresh && k < 40) begin @(negedge clock); k++; end
    check("refresh_period", k, 12);

    k = 0;
    while (!(pass == 3'd7 && draw_player == 2'd0) && k < 60) begin @(negedge clock); k++; end
    check("p0_hp_loop_reached", k < 60, 1);
    lives = {2'd1, 2'd0, 2'd1};

`ifdef PAUSE_EN
    k = 0;
    while (n_events < 16 && k < 200) begin @(negedge clock); k++; end
    check("frame1_done", n_events, 16);
    repeat (4) @(negedge clock);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pass != 3'd0 || refresh) ok = 1'b0;
      @(negedge clock);
    end
    check("paused_idle_quiet", ok, 1);
    pause = 1'b0;
    k = 0;
    while (pass != 3'd2 && k < 6) begin @(negedge clock); k++; end
    check("resume_after_pause", pass, 2);
`endif

    k = 0;
    while (n_events < 30 && k < 400) begin @(negedge clock); k++; end
    check("frame2_done", n_events, 30);
    lives = {2'd2, 2'd0, 2'd0};

    k = 0;
    while (!game_over && k < 20) begin @(negedge clock); k++; end
    check("load_win_outputs", {game_over, screen_sel, pass, copy_enable}, {1'b1, 2'd2, 3'd1, 1'b1});
    check("winner_single", {winner_valid, winner}, {1'b1, 2'd2});
    lives = '0;
    @(negedge clock);
    check("winner_none", {game_over, winner_valid, winner}, {1'b1, 1'b0, 2'd0});

    go = 1'b1;
    k = 0;
    while (game_over && k < 10) begin @(negedge clock); k++; end
    check("win_to_load_title", {game_over, screen_sel, pass}, {1'b0, 2'd0, 3'd1});
    go = 1'b0;
    repeat (10) @(negedge clock);
    check("title_waits_for_go", {screen_sel, pass, player_reset}, {2'd0, 3'd0, 1'b0});

    mon_en = 1'b0;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    k = 0;
    while (!(pass == 3'd4 && draw_idx == 2'd1) && k < 60) begin @(negedge clock); k++; end
    check("second_bomb_reached", k < 60, 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {screen_sel, copy_enable, pass, refresh, draw_idx, draw_player, corner_id},
          {2'd0, 1'b1, 3'd1, 1'b0, 2'd0, 2'd0, 2'd0});
    @(negedge clock);
    check("held_reset_outputs", {screen_sel, copy_enable, pass, refresh, tc_enable, game_over},
          {2'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
